modn_digit_counter: RTL and testbench
=====================================

Name: modn_digit_counter

Overview:
- Parametrised successor of the single-digit mod-10 counter.
- Chains DIGITS modulo-MODULUS digit stages into one multi-digit counter, for example a 4-digit BCD counter for seven-segment display labs.
- Adds count direction, parallel load, and a cascadable combinational roll output so instances can be chained.
- Sits between a clock-enable/tick generator and the display/decoder logic.

Parameters:
- MODULUS, 10: count range per digit, 0..MODULUS-1; legal 2..16.
- WIDTH, 4: bits per digit; must satisfy 2^WIDTH >= MODULUS.
- DIGITS, 4: number of cascaded digit stages; legal 1..8.

Ports:
- clk, input, 1: rising-edge clock.
- resetn, input, 1: synchronous active-low reset.
- enb, input, 1: count enable; one step per clock while high.
- synch, input, 1: synchronous clear to zero.
- up, input, 1: direction; 1 counts up, 0 counts down.
- load, input, 1: parallel load strobe.
- loadValue, input, DIGITS*WIDTH: load data; digit 0 in bits [WIDTH-1:0].
- roll, output, 1: terminal-count-and-enabled flag for cascading.
- currentCount, output, DIGITS*WIDTH: registered count; digit 0 least significant.

Behaviour:
- One clock domain. All state updates on the rising clk edge. Reset is synchronous and active-low.
- Update priority per edge, highest first:
  - resetn=0: all digits 0.
  - synch=1: all digits 0.
  - load=1: currentCount <= loadValue. Any loaded digit >= MODULUS is stored as 0.
  - enb=1: count one step.
  - Otherwise: hold.
- Counting up:
  - Digit 0 steps every enabled cycle.
  - Digit i steps only when digits 0..i-1 are all MODULUS-1.
  - A stepping digit that is at MODULUS-1 wraps to 0; otherwise it increments by 1.
- Counting down:
  - Digit i steps only when digits 0..i-1 are all 0.
  - A stepping digit that is at 0 wraps to MODULUS-1; otherwise it decrements by 1.
- Full wrap: up from all digits MODULUS-1 gives all 0. Down from all 0 gives all MODULUS-1.
- roll is combinational, with no register:
  - up=1: roll = enb & every digit == MODULUS-1.
  - up=0: roll = enb & every digit == 0.
  - roll is forced 0 while synch=1 or load=1.
- Cascading: a downstream instance's enb connects to an upstream instance's roll, giving a single-cycle carry.
- Latency:
  - Count, load, and clear take effect on the next edge.
  - roll reflects the current register value and input levels in the same cycle.
- up may change on any cycle; the new direction applies from that edge. There is no hidden state.
- Reset or synch mid-count discards the count with no partial-digit effects.
- Reset values: currentCount = 0. roll = 0 whenever enb=0 or up=1; it is combinational, so with enb=1, up=0 and count 0 it can assert immediately after reset.
- Arithmetic: per-digit WIDTH-bit compare against MODULUS-1 and 0. There is no binary carry across digit boundaries.

Optional Feature:
- Macro: MODN_COUNTER_SATURATE_EN.
- Defined:
  - Counting saturates instead of wrapping. Up holds at all MODULUS-1; down holds at all 0.
  - roll still asserts at the terminal value while enb=1, so it stays high while saturated.
  - load and synch behave exactly as without the macro.
- Undefined: wrap-around behaviour as described above.

Decomposition:
- Shared package/header modn_counter_pkg holds:
  - default localparams MODULUS_DEFAULT=10, WIDTH_DEFAULT=4;
  - function digitTerminal(value, up), returning the terminal-value compare.
- Natural sub-module: modn_digit, one digit stage.
  - Ports: clk, resetn, synch, load, loadDigit, up, carryIn, digit, carryOut.
  - Instantiated DIGITS times by a generate loop.
  - carryOut = carryIn & terminal; it feeds the next stage's carryIn.
  - Top-level roll = carryOut of the last stage.

Test Plan:
- Up count: reset, enb=1, up=1, DIGITS=2, MODULUS=10, 100 cycles. Count runs 00..99 then 00. roll high exactly in the cycle showing 99.
- Down wrap: load 8'h00 with up=0, then enb=1 for 1 cycle. Count becomes 99. roll was high during the 00 cycle.
- Load validation: load 16'h9C37 with MODULUS=10, DIGITS=4. currentCount = 16'h9037 (digit C invalid, stored as 0). Next enabled up cycle gives 9038.
- Priority: resetn=1, synch=1, load=1, enb=1 in the same cycle at count 0042. Next value is 0000 and roll=0 throughout.
- Cascade: two instances with DIGITS=1, MODULUS=6 and MODULUS=10, the mod-10 stage's roll feeding the mod-6 stage's enb (seconds counter). After 60 enabled cycles, count reads 0:0 and the mod-6 stage's roll pulsed once at 5:9.
- Saturate build with MODN_COUNTER_SATURATE_EN defined: count up past 99 and hold 99 with roll=1 steady. Then synch=1 gives 00 next edge.

Source files
------------

// File: rtl/modn_counter_pkg.sv
// Shared defaults and the per-digit terminal-value compare for the mod-N digit counter.
package modn_counter_pkg;

  localparam int MODULUS_DEFAULT = 10;
  localparam int WIDTH_DEFAULT   = 4;

  // Terminal value is MODULUS-1 when counting up and 0 when counting down.
  function automatic logic digitTerminal(input int value, input logic up,
                                         input int modulus = MODULUS_DEFAULT);
    return up ? (value == modulus - 1) : (value == 0);
  endfunction

endpackage

// File: rtl/modn_digit_counter_if.sv
// Control/data bundle between a tick source and the mod-N digit counter.
// Plain level signals, no handshake: the counter samples enb/synch/load/up every clk edge.
interface modn_digit_counter_if
  import modn_counter_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int DIGITS = 4
);
  logic                      enb;
  logic                      synch;
  logic                      up;
  logic                      load;
  logic [DIGITS*WIDTH-1:0]   loadValue;
  logic                      roll;
  logic [DIGITS*WIDTH-1:0]   currentCount;

  modport master (
    output enb, synch, up, load, loadValue,
    input  roll, currentCount
  );

  modport slave (
    input  enb, synch, up, load, loadValue,
    output roll, currentCount
  );
endinterface

// File: rtl/modn_digit.sv
// One modulo-MODULUS digit stage; steps when carryIn is high, passes carry on at its terminal value.
module modn_digit
  import modn_counter_pkg::*;
#(
  parameter int MODULUS = MODULUS_DEFAULT,
  parameter int WIDTH   = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             synch,
  input  logic             load,
  input  logic [WIDTH-1:0] loadDigit,
  input  logic             up,
  input  logic             carryIn,
  input  logic             hold,
  output logic [WIDTH-1:0] digit,
  output logic             carryOut
);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] digit_q, digit_d;
  logic             terminal;

  assign terminal = digitTerminal(32'(digit_q), up, MODULUS);
  assign carryOut = carryIn & terminal;
  assign digit    = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (synch) begin
      digit_d = '0;
    end else if (load) begin
      digit_d = (32'(loadDigit) >= MODULUS) ? '0 : loadDigit;
    end else if (carryIn && !hold) begin
      if (up) digit_d = terminal ? '0 : digit_q + 1'b1;
      else    digit_d = terminal ? MAX_VAL : digit_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) digit_q <= '0;
    else         digit_q <= digit_d;
  end

endmodule

// File: rtl/modn_digit_counter.sv
// DIGITS cascaded mod-MODULUS digits with direction, parallel load and combinational roll.
// Define MODN_COUNTER_SATURATE_EN to hold at the terminal value instead of wrapping.
module modn_digit_counter
  import modn_counter_pkg::*;
#(
  parameter int MODULUS = MODULUS_DEFAULT,
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int DIGITS  = 4
) (
  input logic                 clk,
  input logic                 resetn,
  modn_digit_counter_if.slave bus
);
  logic [DIGITS:0] carry;
  logic            hold;

  // Clear and load outrank counting, so they also suppress the carry chain and roll.
  assign carry[0] = bus.enb & ~bus.synch & ~bus.load;

`ifdef MODN_COUNTER_SATURATE_EN
  assign hold = carry[DIGITS];
`else
  assign hold = 1'b0;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    modn_digit #(
      .MODULUS (MODULUS),
      .WIDTH   (WIDTH)
    ) u_digit (
      .clk       (clk),
      .resetn    (resetn),
      .synch     (bus.synch),
      .load      (bus.load),
      .loadDigit (bus.loadValue[i*WIDTH +: WIDTH]),
      .up        (bus.up),
      .carryIn   (carry[i]),
      .hold      (hold),
      .digit     (bus.currentCount[i*WIDTH +: WIDTH]),
      .carryOut  (carry[i+1])
    );
  end

  assign bus.roll = carry[DIGITS];

endmodule

// File: tb/tb_modn_digit_counter.sv
// Randomized and directed bench for modn_digit_counter against a mixed-radix integer model.
module tb_modn_digit_counter;
`ifdef MODN_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  modn_digit_counter_if #(.WIDTH(4), .DIGITS(2)) if2 ();
  modn_digit_counter_if #(.WIDTH(4), .DIGITS(4)) if4 ();
  modn_digit_counter_if #(.WIDTH(3), .DIGITS(3)) if7 ();
  modn_digit_counter_if #(.WIDTH(4), .DIGITS(1)) ifs ();
  modn_digit_counter_if #(.WIDTH(4), .DIGITS(1)) ifm ();

  assign ifm.enb = ifs.roll;

  modn_digit_counter #(.MODULUS(10), .WIDTH(4), .DIGITS(2)) u2 (.clk(clk), .resetn(resetn), .bus(if2));
  modn_digit_counter #(.MODULUS(10), .WIDTH(4), .DIGITS(4)) u4 (.clk(clk), .resetn(resetn), .bus(if4));
  modn_digit_counter #(.MODULUS(7),  .WIDTH(3), .DIGITS(3)) u7 (.clk(clk), .resetn(resetn), .bus(if7));
  modn_digit_counter #(.MODULUS(10), .WIDTH(4), .DIGITS(1)) us (.clk(clk), .resetn(resetn), .bus(ifs));
  modn_digit_counter #(.MODULUS(6),  .WIDTH(4), .DIGITS(1)) um (.clk(clk), .resetn(resetn), .bus(ifm));

  // Model: the whole counter is one integer in 0..total-1, total = MODULUS**DIGITS.
  function automatic int pow_i(int b, int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic int step_val(int v, bit up, int total);
    if (up) return (v == total - 1) ? (SAT ? v : 0) : v + 1;
    else    return (v == 0) ? (SAT ? 0 : total - 1) : v - 1;
  endfunction

  function automatic logic [31:0] encode(int v, int m, int w, int d);
    logic [31:0] r = '0;
    int          x = v;
    for (int i = 0; i < d; i++) begin
      r = r | (32'(x % m) << (i * w));
      x = x / m;
    end
    return r;
  endfunction

  function automatic int decode_load(logic [31:0] lv, int m, int w, int d);
    int v = 0;
    for (int i = 0; i < d; i++) begin
      int dig;
      dig = int'((lv >> (i * w)) & ((32'd1 << w) - 32'd1));
      if (dig >= m) dig = 0;
      v = v + dig * pow_i(m, i);
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] z;
    z = '0;
    resetn = 1'b0;
    if2.enb = 1'b1; if2.load = 1'b1; if2.loadValue = 8'h55; if2.up = 1'b1;
    if4.load = 1'b1; if4.loadValue = 16'h1234;
    repeat (2) tick();
    if (if2.currentCount !== z[7:0])  begin failures++; $display("FAIL reset_if2 got=%h exp=%h", if2.currentCount, z[7:0]); end
    if (if4.currentCount !== z[15:0]) begin failures++; $display("FAIL reset_if4 got=%h exp=%h", if4.currentCount, z[15:0]); end
    if (if7.currentCount !== z[8:0])  begin failures++; $display("FAIL reset_if7 got=%h exp=%h", if7.currentCount, z[8:0]); end
    if (ifs.currentCount !== z[3:0])  begin failures++; $display("FAIL reset_ifs got=%h exp=%h", ifs.currentCount, z[3:0]); end
    if (ifm.currentCount !== z[3:0])  begin failures++; $display("FAIL reset_ifm got=%h exp=%h", ifm.currentCount, z[3:0]); end
    checks += 5;
    resetn = 1'b1;
    if2.load = 1'b0; if2.up = 1'b0; if2.enb = 1'b1;
    if4.load = 1'b0;
    #1;
    checks++;
    if (if2.roll !== 1'b1) begin failures++; $display("FAIL reset_roll_down got=%b exp=1", if2.roll); end
    if2.up = 1'b1;
    #1;
    checks++;
    if (if2.roll !== 1'b0) begin failures++; $display("FAIL reset_roll_up got=%b exp=0", if2.roll); end
    if2.enb = 1'b0;
    #1;
  endtask

  task automatic test_up_count();
    int v = 0;
    logic [31:0] e;
    if2.up = 1'b1; if2.enb = 1'b1;
    for (int c = 0; c <= 100; c++) begin
      #1;
      e = encode(v, 10, 4, 2);
      checks += 2;
      if (if2.currentCount !== e[7:0]) begin failures++; $display("FAIL up_count c=%0d got=%h exp=%h", c, if2.currentCount, e[7:0]); end
      if (if2.roll !== (v == 99)) begin failures++; $display("FAIL up_roll c=%0d got=%b exp=%b", c, if2.roll, (v == 99)); end
      tick();
      v = step_val(v, 1'b1, 100);
    end
    if2.enb = 1'b0;
  endtask

  task automatic test_down_wrap();
    int v;
    logic [31:0] e;
    if2.synch = 1'b1; tick(); if2.synch = 1'b0;
    if2.load = 1'b1; if2.loadValue = 8'h00; if2.up = 1'b0; if2.enb = 1'b1;
    #1;
    checks++;
    if (if2.roll !== 1'b0) begin failures++; $display("FAIL down_load_roll got=%b exp=0", if2.roll); end
    tick();
    if2.load = 1'b0;
    #1;
    checks += 2;
    if (if2.currentCount !== 8'h00) begin failures++; $display("FAIL down_zero got=%h exp=00", if2.currentCount); end
    if (if2.roll !== 1'b1) begin failures++; $display("FAIL down_roll got=%b exp=1", if2.roll); end
    tick();
    if2.enb = 1'b0;
    v = step_val(0, 1'b0, 100);
    e = encode(v, 10, 4, 2);
    #1;
    checks += 2;
    if (if2.currentCount !== e[7:0]) begin failures++; $display("FAIL down_wrap got=%h exp=%h", if2.currentCount, e[7:0]); end
    if (if2.roll !== 1'b0) begin failures++; $display("FAIL down_idle_roll got=%b exp=0", if2.roll); end
  endtask

  task automatic test_load_validation();
    logic [15:0] pat [3];
    logic [31:0] e;
    int v;
    pat[0] = 16'h9C37; pat[1] = 16'hFAB0; pat[2] = 16'h0999;
    for (int k = 0; k < 3; k++) begin
      if4.load = 1'b1; if4.loadValue = pat[k]; if4.enb = 1'b1; if4.up = 1'b1;
      tick();
      if4.load = 1'b0;
      v = decode_load(32'(pat[k]), 10, 4, 4);
      e = encode(v, 10, 4, 4);
      #1;
      checks++;
      if (if4.currentCount !== e[15:0]) begin failures++; $display("FAIL load_val k=%0d got=%h exp=%h", k, if4.currentCount, e[15:0]); end
      tick();
      if4.enb = 1'b0;
      e = encode(step_val(v, 1'b1, 10000), 10, 4, 4);
      #1;
      checks++;
      if (if4.currentCount !== e[15:0]) begin failures++; $display("FAIL load_step k=%0d got=%h exp=%h", k, if4.currentCount, e[15:0]); end
    end
  endtask

  task automatic test_priority();
    if4.load = 1'b1; if4.loadValue = 16'h0042;
    tick();
    if4.load = 1'b0;
    #1;
    checks++;
    if (if4.currentCount !== 16'h0042) begin failures++; $display("FAIL prio_load got=%h exp=0042", if4.currentCount); end
    if4.synch = 1'b1; if4.load = 1'b1; if4.enb = 1'b1; if4.up = 1'b1; if4.loadValue = 16'h5678;
    #1;
    checks++;
    if (if4.roll !== 1'b0) begin failures++; $display("FAIL prio_roll got=%b exp=0", if4.roll); end
    tick();
    checks += 2;
    if (if4.currentCount !== 16'h0000) begin failures++; $display("FAIL prio_clear got=%h exp=0000", if4.currentCount); end
    if4.load = 1'b0; if4.up = 1'b0;
    #1;
    if (if4.roll !== 1'b0) begin failures++; $display("FAIL prio_synch_roll got=%b exp=0", if4.roll); end
    if4.synch = 1'b0; if4.enb = 1'b0;
    if4.load = 1'b1; if4.loadValue = 16'h1234; resetn = 1'b0;
    tick();
    resetn = 1'b1; if4.load = 1'b0;
    #1;
    checks++;
    if (if4.currentCount !== 16'h0000) begin failures++; $display("FAIL prio_reset got=%h exp=0000", if4.currentCount); end
  endtask

  task automatic test_cascade();
    int u = 0, t = 0;
    bit ur, tr;
    logic [3:0] eu, et;
    ifs.synch = 1'b1; ifm.synch = 1'b1; tick();
    ifs.synch = 1'b0; ifm.synch = 1'b0;
    ifs.load = 1'b0; ifm.load = 1'b0; ifs.up = 1'b1; ifm.up = 1'b1; ifs.enb = 1'b1;
    for (int c = 0; c <= 60; c++) begin
      #1;
      ur = (u == 9);
      tr = ur && (t == 5);
      eu = 4'(u); et = 4'(t);
      checks += 4;
      if (ifs.currentCount !== eu) begin failures++; $display("FAIL casc_units c=%0d got=%h exp=%h", c, ifs.currentCount, eu); end
      if (ifm.currentCount !== et) begin failures++; $display("FAIL casc_tens c=%0d got=%h exp=%h", c, ifm.currentCount, et); end
      if (ifs.roll !== ur) begin failures++; $display("FAIL casc_uroll c=%0d got=%b exp=%b", c, ifs.roll, ur); end
      if (ifm.roll !== tr) begin failures++; $display("FAIL casc_troll c=%0d got=%b exp=%b", c, ifm.roll, tr); end
      tick();
      if (ur) t = step_val(t, 1'b1, 6);
      u = step_val(u, 1'b1, 10);
    end
    ifs.enb = 1'b0;
  endtask

  task automatic test_random();
    int v = 0;
    logic [31:0] e;
    logic er;
    if7.synch = 1'b1; tick(); if7.synch = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if7.enb   = ($urandom_range(0, 3) != 0);
      if7.up    = 1'($urandom_range(0, 1));
      if7.load  = ($urandom_range(0, 15) == 0);
      if7.synch = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       if7.loadValue = 9'o666;
        1:       if7.loadValue = 9'o000;
        default: if7.loadValue = 9'($urandom);
      endcase
      #1;
      e  = encode(v, 7, 3, 3);
      er = if7.enb && !if7.synch && !if7.load && (if7.up ? (v == 342) : (v == 0));
      checks += 2;
      if (if7.currentCount !== e[8:0]) begin failures++; $display("FAIL rand_count c=%0d got=%o exp=%o", c, if7.currentCount, e[8:0]); end
      if (if7.roll !== er) begin failures++; $display("FAIL rand_roll c=%0d got=%b exp=%b", c, if7.roll, er); end
      tick();
      if (if7.synch)     v = 0;
      else if (if7.load) v = decode_load(32'(if7.loadValue), 7, 3, 3);
      else if (if7.enb)  v = step_val(v, if7.up, 343);
    end
    if7.enb = 1'b0; if7.load = 1'b0; if7.synch = 1'b0;
  endtask

  task automatic test_saturate();
    int v = 98;
    logic [31:0] e;
    if2.load = 1'b1; if2.loadValue = 8'h98; tick(); if2.load = 1'b0;
    if2.up = 1'b1; if2.enb = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      e = encode(v, 10, 4, 2);
      checks += 2;
      if (if2.currentCount !== e[7:0]) begin failures++; $display("FAIL sat_count c=%0d got=%h exp=%h", c, if2.currentCount, e[7:0]); end
      if (if2.roll !== (v == 99)) begin failures++; $display("FAIL sat_roll c=%0d got=%b exp=%b", c, if2.roll, (v == 99)); end
      tick();
      v = step_val(v, 1'b1, 100);
    end
    if2.synch = 1'b1;
    tick();
    if2.synch = 1'b0; if2.enb = 1'b0;
    #1;
    checks++;
    if (if2.currentCount !== 8'h00) begin failures++; $display("FAIL sat_clear got=%h exp=00", if2.currentCount); end
  endtask

  initial begin
    resetn = 1'b0;
    if2.enb = 1'b0; if2.synch = 1'b0; if2.up = 1'b1; if2.load = 1'b0; if2.loadValue = '0;
    if4.enb = 1'b0; if4.synch = 1'b0; if4.up = 1'b1; if4.load = 1'b0; if4.loadValue = '0;
    if7.enb = 1'b0; if7.synch = 1'b0; if7.up = 1'b1; if7.load = 1'b0; if7.loadValue = '0;
    ifs.enb = 1'b0; ifs.synch = 1'b0; ifs.up = 1'b1; ifs.load = 1'b0; ifs.loadValue = '0;
    ifm.synch = 1'b0; ifm.up = 1'b1; ifm.load = 1'b0; ifm.loadValue = '0;
    test_reset();
    test_up_count();
    test_down_wrap();
    test_load_validation();
    test_priority();
    test_cascade();
    test_random();
    if (SAT) test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
